// File: rtl/miriscv_int_ctrl.sv
// miriscv_int_ctrl: round-robin interrupt controller for the core.
// Masks int_req_i with mie_i, scans one index per cycle from cnt,
// latches the first hit and raises int_o with mcause_o.
// On int_rst_i it strobes int_fin_o one-hot for one cycle and
// resumes scanning just past the serviced line.
// Ports:
//   clk_i, rst_n_i   clock, sync active-low reset
//   int_req_i        level requests from devices
//   mie_i            enable mask
//   int_rst_i        handler-finished pulse from core
//   int_o            interrupt pending to core
//   mcause_o         {1, zeros, id}
//   int_fin_o        one-hot completion strobe
module miriscv_int_ctrl #(
  parameter int N_IRQ = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [N_IRQ-1:0] int_req_i,
  input  logic [N_IRQ-1:0] mie_i,
  input  logic             int_rst_i,
  output logic             int_o,
  output logic [31:0]      mcause_o,
  output logic [N_IRQ-1:0] int_fin_o
);

  localparam int IW = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;
  localparam logic [IW-1:0] LAST = IW'(N_IRQ - 1);
  localparam logic [N_IRQ-1:0] ONE =
    {{(N_IRQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    id_q, id_d;
  logic             int_q, int_d;
  logic [31:0]      mcause_q, mcause_d;
  logic [N_IRQ-1:0] fin_q, fin_d;

  logic [N_IRQ-1:0] masked;
  logic             hit;

  assign masked = int_req_i & mie_i;
  assign hit    = masked[cnt_q];

  function automatic logic [IW-1:0] wrap_inc(
    input logic [IW-1:0] v
  );
    return (v == LAST) ? '0 : v + 1'b1;
  endfunction

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    id_d     = id_q;
    int_d    = int_q;
    mcause_d = mcause_q;
    fin_d    = '0;
    unique case (state_q)
      IDLE: begin
        if (hit) begin
          id_d     = cnt_q;
          state_d  = BUSY;
          int_d    = 1'b1;
          mcause_d = {1'b1, {(31-IW){1'b0}}, cnt_q};
        end else begin
          cnt_d = wrap_inc(cnt_q);
        end
      end
      BUSY: begin
        // Request lines are ignored here: the latched
        // id is completed even if its request dropped.
        if (int_rst_i) begin
          state_d = FIN;
          int_d   = 1'b0;
          fin_d   = ONE << id_q;
        end
      end
      FIN: begin
        // Resume just past the serviced line so a
        // still-held request cannot starve others.
        state_d = IDLE;
        cnt_d   = wrap_inc(id_q);
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      id_q     <= '0;
      int_q    <= 1'b0;
      mcause_q <= '0;
      fin_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      id_q     <= id_d;
      int_q    <= int_d;
      mcause_q <= mcause_d;
      fin_q    <= fin_d;
    end
  end

  assign int_o     = int_q;
  assign mcause_o  = mcause_q;
  assign int_fin_o = fin_q;

endmodule

// File: tb/tb_miriscv_int_ctrl.sv
// Scoreboard bench for miriscv_int_ctrl.
// Expected services come from a scan-position model.
module tb_miriscv_int_ctrl;

  localparam int N = 32;

  typedef struct {
    logic [31:0] val;
    int unsigned cyc;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  req;
  logic [N-1:0]  mie;
  logic          int_rst;
  logic          int_o;
  logic [31:0]   mcause;
  logic [N-1:0]  fin;

  miriscv_int_ctrl #(.N_IRQ(N)) dut (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .int_req_i (req),
    .mie_i     (mie),
    .int_rst_i (int_rst),
    .int_o     (int_o),
    .mcause_o  (mcause),
    .int_fin_o (fin)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  logic        rst_edge = 1'b1;
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_edge <= !rst_n;
  end

  int   n_cmp = 0;
  int   n_fail = 0;
  exp_t rise_q[$];
  exp_t fin_q[$];

  // Model: scan position is p at cycle idle_start and
  // advances one index per idle cycle thereafter.
  int unsigned idle_start = 0;
  int          p = 0;
  int          cur_id = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h @cyc %0d",
               nm, act, exp, cyc);
    end
  endtask

  function automatic int pick(input logic [N-1:0] m,
                              input int c);
    for (int i = 0; i < N; i++) begin
      if (m[(c + i) % N]) return (c + i) % N;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic gap_vals();
    logic [N-1:0] r;
    r   = $urandom;
    req = r;
    mie = $urandom & ~r;
  endtask

  task automatic gap(input int g, input bit pulses);
    for (int i = 0; i < g; i++) begin
      gap_vals();
      int_rst = pulses && ($urandom_range(0, 3) == 0);
      tick();
    end
    int_rst = 1'b0;
  endtask

  task automatic issue(input logic [N-1:0] rq,
                       input logic [N-1:0] me);
    int unsigned x;
    int unsigned base;
    int c;
    int k;
    exp_t e;
    x = cyc;
    if (x < idle_start) begin
      c    = p;
      base = idle_start;
    end else begin
      c    = (p + int'(x - idle_start)) % N;
      base = x;
    end
    k   = pick(rq & me, c);
    req = rq;
    mie = me;
    if (k >= 0) begin
      e.val  = 32'h8000_0000 | 32'(k);
      e.cyc  = base + 32'(((k - c + N) % N) + 1);
      rise_q.push_back(e);
      cur_id = k;
    end
  endtask

  task automatic wait_int();
    for (int i = 0; i < N + 6; i++) begin
      if (int_o) break;
      tick();
    end
    chk("int_o_timeout", {31'b0, int_o}, 32'd1);
    if (!int_o) rise_q.delete();
  endtask

  task automatic push_fin(input int id);
    exp_t e;
    e.val = 32'd1 << id;
    e.cyc = cyc + 1;
    fin_q.push_back(e);
  endtask

  task automatic finish(input int id, input int hold,
                        input int mode, input bit lng);
    for (int i = 0; i < hold; i++) begin
      if (mode == 1) begin
        req = $urandom;
        mie = $urandom;
      end else if (mode == 2) begin
        req = (i == 0) ? '0 : 32'h200;
        mie = '1;
      end
      tick();
    end
    int_rst = 1'b1;
    push_fin(id);
    tick();
    gap_vals();
    if (!lng) int_rst = 1'b0;
    idle_start = cyc + 1;
    p = (id + 1) % N;
    if (lng) begin
      tick();
      int_rst = 1'b0;
    end
  endtask

  task automatic do_reset(input int n,
                          input logic [N-1:0] rq);
    rst_n = 1'b0;
    req   = rq;
    mie   = '1;
    for (int i = 0; i < n; i++) begin
      tick();
      chk("rst_int_o", {31'b0, int_o}, 32'd0);
      chk("rst_mcause", mcause, 32'd0);
      chk("rst_fin", fin, 32'd0);
    end
    rst_n = 1'b1;
    gap_vals();
    idle_start = cyc;
    p = 0;
  endtask

  // Monitor: compares DUT events against queued expectations.
  logic        prev_int = 1'b0;
  logic [31:0] prev_mc = '0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_edge) begin
      if (int_o && !prev_int) begin
        if (rise_q.size() == 0) begin
          chk("rise_unexpected", mcause, 32'hffff_ffff);
        end else begin
          e = rise_q.pop_front();
          chk("mcause", mcause, e.val);
          chk("rise_cyc", cyc, e.cyc);
        end
      end else begin
        chk("mcause_hold", mcause, prev_mc);
      end
      if (!int_o && prev_int)
        chk("fall_with_fin", {31'b0, fin != 0}, 32'd1);
      if (fin != 0) begin
        if (fin_q.size() == 0) begin
          chk("fin_unexpected", fin, 32'd0);
        end else begin
          e = fin_q.pop_front();
          chk("fin_val", fin, e.val);
          chk("fin_cyc", cyc, e.cyc);
          chk("fin_int_low", {31'b0, int_o}, 32'd0);
        end
      end
    end
    prev_int = int_o;
    prev_mc  = mcause;
  end

  initial begin
    logic [N-1:0] r;
    logic [N-1:0] m;
    int b;
    rst_n   = 1'b0;
    req     = '1;
    mie     = '1;
    int_rst = 1'b0;

    do_reset(2, '1);

    issue(32'h20, '1);
    wait_int();
    finish(cur_id, 2, 0, 0);
    gap(3, 1);

    req = 32'h8;
    mie = '0;
    for (int i = 0; i < 100; i++) tick();
    chk("mask_int_o", {31'b0, int_o}, 32'd0);
    issue(32'h8, 32'h8);
    wait_int();
    finish(cur_id, 1, 0, 0);

    do_reset(1, '0);
    for (int i = 0; i < 3; i++) begin
      issue(32'h88, '1);
      wait_int();
      finish(cur_id, 1, 0, 0);
    end

    issue(32'h4, '1);
    wait_int();
    finish(cur_id, 3, 2, 0);
    gap(20, 1);

    issue(32'h1000, '1);
    wait_int();
    tick();
    do_reset(1, $urandom);
    issue(32'h1, '1);
    wait_int();
    int_rst = 1'b1;
    push_fin(cur_id);
    tick();
    int_rst = 1'b0;
    do_reset(1, '1);
    issue(32'h1, '1);
    wait_int();
    finish(cur_id, 0, 0, 0);

    for (int t = 0; t < 150; t++) begin
      gap($urandom_range(0, 40), 1'b1);
      r = $urandom;
      m = $urandom;
      if ((r & m) == 0) begin
        b    = $urandom_range(0, N - 1);
        r[b] = 1'b1;
        m[b] = 1'b1;
      end
      issue(r, m);
      wait_int();
      finish(cur_id, $urandom_range(0, 5),
             $urandom_range(0, 1), $urandom_range(0, 1));
    end

    gap(5, 1'b0);
    chk("rise_q_empty", rise_q.size(), 32'd0);
    chk("fin_q_empty", fin_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule
